// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: holds the PC, fetches one 16-bit word per handshake,
// presents it to the decoder and picks the next PC when the word is accepted.
module inst_fetch_unit #(
  parameter int                     WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0]   RESET_PC  = '0,
  parameter int                     TGT_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_read,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_data,
  input  logic                 mem_ready,
  output logic [WORD_SIZE-1:0] inst,
  output logic                 inst_valid,
  input  logic                 inst_accept,
  input  logic                 pc_src1,
  input  logic                 pc_src2,
  input  logic [WORD_SIZE-1:0] jump_reg_val,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] pc_plus1,
  output logic [WORD_SIZE-1:0] num_inst
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] r_inst;
  logic                 r_inst_valid;
  logic                 r_mem_read;
  logic [WORD_SIZE-1:0] r_num_inst;

  logic [WORD_SIZE-1:0] w_pc_plus1;
  logic [WORD_SIZE-1:0] w_jump_tgt;
  logic [WORD_SIZE-1:0] w_next_pc;

  assign w_pc_plus1 = r_pc + ONE;
  // J-type target keeps the page bits of the current pc, not of pc+1.
  assign w_jump_tgt = {r_pc[WORD_SIZE-1:TGT_BITS], r_inst[TGT_BITS-1:0]};

  always_comb begin
    w_next_pc = w_pc_plus1;
    if (pc_src2)      w_next_pc = jump_reg_val;
    else if (pc_src1) w_next_pc = w_jump_tgt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_mem_read   <= 1'b0;
      r_num_inst   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_mem_read <= 1'b1;
        end
        S_FETCH: begin
          if (mem_ready) begin
            r_inst       <= mem_data;
            r_inst_valid <= 1'b1;
            r_mem_read   <= 1'b0;
            r_state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Re-request on the accept edge so there is no bubble before the next fetch.
          if (inst_accept) begin
            r_pc         <= w_next_pc;
            r_num_inst   <= r_num_inst + ONE;
            r_inst_valid <= 1'b0;
            r_mem_read   <= 1'b1;
            r_state      <= S_FETCH;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_mem_read <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read   = r_mem_read;
  assign mem_addr   = r_pc;
  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign pc         = r_pc;
  assign pc_plus1   = w_pc_plus1;
  assign num_inst   = r_num_inst;

endmodule
